bus_fabric: RTL and testbench
=============================

BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 The block SHALL have parameter NUM_DEV, default 4, number of bus agents (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 4, shared data bus width.
REQ-003 The block SHALL have parameter KEEP, default 0, where 1 enables the bus keeper and 0 drives zero when idle.
REQ-004 The block SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port sync  input  1  instruction-cycle marker from the CPU, high for one clock in phase X3.
REQ-007 The block SHALL have port dev_data_o  input  NUM_DEV*DATA_W  per-agent drive value, agent i at bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port dev_data_en  input  NUM_DEV  per-agent drive enable.
REQ-009 The block SHALL have port clear_err  input  1  clears sticky error state.
REQ-010 The block SHALL have port data  output  DATA_W  resolved bus value, fed back to every agent's data input.
REQ-011 The block SHALL have port phase  output  3  current bus phase: 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3.
REQ-012 The block SHALL have port phase_valid  output  1  high once the phase tracker has locked to sync.
REQ-013 The block SHALL have port contention  output  1  registered one-clock pulse when two or more enables were high in the previous clock.
REQ-014 The block SHALL have port err_contention  output  1  sticky contention flag.
REQ-015 The block SHALL have port err_sync  output  1  sticky flag for a sync arriving early or missing.
REQ-016 The block SHALL have port conflict_mask  output  NUM_DEV  dev_data_en snapshot of the most recent contention.
REQ-017 The block SHALL have port conflict_count  output  8  saturating count of contention clocks.

Function
REQ-018 The data output SHALL be combinational, with the lowest-index enabled agent winning.
REQ-019 With no enable high and KEEP=0, data SHALL be all zeros.
REQ-020 With no enable high and KEEP=1, data SHALL equal a register holding the last value driven by any agent; this register is updated every clock in which any enable is high.
REQ-021 The phase tracker SHALL be unlocked (phase_valid=0, phase=7) until the first sync; on sync, phase SHALL become 7 that clock and advance to 0 (A1) the next clock, with phase_valid=1 from that clock on.
REQ-022 When locked, phase SHALL increment by 1 per clock, wrapping 7->0.
REQ-023 A sync seen while locked and phase!=6 in the prior clock (i.e. early sync) SHALL force phase to 7, keep lock and set err_sync.
REQ-024 A locked wrap from 7->0 with sync low during phase 7 SHALL set err_sync; the tracker SHALL continue free-running.
REQ-025 Contention SHALL be two or more bits of dev_data_en high in a clock, regardless of phase or value equality.
REQ-026 On contention, the next clock SHALL show contention=1, err_contention=1, conflict_mask=that clock's dev_data_en, and conflict_count incremented.
REQ-027 conflict_count SHALL saturate at 255 and not wrap.
REQ-028 clear_err SHALL zero err_contention, err_sync, conflict_mask and conflict_count next clock; it SHALL NOT affect the phase tracker, keeper or contention pulse.
REQ-029 If clear_err coincides with a new error event, the new event SHALL win: the flag is set, the mask is captured and the count becomes 1.
REQ-030 A single enable SHALL never set any error output.

Reset
REQ-031 Reset SHALL drive phase=7, phase_valid=0, contention=0, err_contention=0, err_sync=0, conflict_mask=0, conflict_count=0 and keeper=0 on the next clock.
REQ-032 Reset asserted mid-cycle SHALL drop lock; relock SHALL require a fresh sync.
REQ-033 The data path SHALL remain combinational during reset; with KEEP=1 and no enables, data SHALL read 0 after reset.

Verification
REQ-034 Scenario 1: reset; sync pulse; run 16 clocks with sync every 8th clock -> phase_valid=1, phase sequence 0..7,0..7, err_sync=0.
REQ-035 Scenario 2: en=0b0110, agent1=0x5, agent2=0xA -> data=0x5; next clock contention=1, conflict_mask=0b0110, conflict_count=1, err_contention=1.
REQ-036 Scenario 3: KEEP=1; agent3 drives 0xC for one clock then all enables low -> data stays 0xC; with KEEP=0 data=0x0.
REQ-037 Scenario 4: locked; sync at phase 3 -> phase=7 that clock, err_sync=1; then omit sync for one cycle -> err_sync remains 1, phase keeps wrapping.
REQ-038 Scenario 5: hold two enables for 300 clocks -> conflict_count=255; clear_err with contention still present -> count=1, err_contention=1.
REQ-039 Scenario 6: reset asserted at phase 4 while locked -> phase_valid=0, all errors 0; no relock until next sync.

Source files
------------

// File: rtl/bus_fabric.sv
// Shared-bus fabric. It resolves the data bus with a lowest-index priority and an optional keeper.
// It also tracks the instruction-cycle phase against the CPU sync marker and records drive contention.
module bus_fabric #(
  parameter int NUM_DEV = 4,
  parameter int DATA_W  = 4,
  parameter int KEEP    = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sync,
  input  logic [NUM_DEV*DATA_W-1:0] dev_data_o,
  input  logic [NUM_DEV-1:0]        dev_data_en,
  input  logic                      clear_err,
  output logic [DATA_W-1:0]         data,
  output logic [2:0]                phase,
  output logic                      phase_valid,
  output logic                      contention,
  output logic                      err_contention,
  output logic                      err_sync,
  output logic [NUM_DEV-1:0]        conflict_mask,
  output logic [7:0]                conflict_count
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  localparam logic [NUM_DEV-1:0] EN_ONE = NUM_DEV'(1);

  lock_state_t         lock_q, lock_d;
  logic [2:0]          phase_q, phase_d;
  logic                contention_q, contention_d;
  logic                err_contention_q, err_contention_d;
  logic                err_sync_q, err_sync_d;
  logic [NUM_DEV-1:0]  conflict_mask_q, conflict_mask_d;
  logic [7:0]          conflict_count_q, conflict_count_d;
  logic [DATA_W-1:0]   keeper_q, keeper_d;

  logic [DATA_W-1:0]   win_data;
  logic                any_en;
  logic                multi_en;
  logic                sync_err;

  // The scan runs from the top index downward, so the lowest enabled agent is written last and wins.
  always_comb begin
    win_data = '0;
    any_en   = 1'b0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (dev_data_en[i]) begin
        win_data = dev_data_o[i*DATA_W +: DATA_W];
        any_en   = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more enables are high.
  assign multi_en = |(dev_data_en & (dev_data_en - EN_ONE));

  assign data           = any_en ? win_data : ((KEEP != 0) ? keeper_q : '0);
  assign phase          = sync ? 3'd7 : phase_q;
  assign phase_valid    = (lock_q == LOCKED);
  assign contention     = contention_q;
  assign err_contention = err_contention_q;
  assign err_sync       = err_sync_q;
  assign conflict_mask  = conflict_mask_q;
  assign conflict_count = conflict_count_q;

  always_comb begin
    lock_d   = lock_q;
    phase_d  = phase_q;
    sync_err = 1'b0;
    case (lock_q)
      UNLOCKED: begin
        phase_d = 3'd7;
        if (sync) begin
          lock_d  = LOCKED;
          phase_d = 3'd0;
        end
      end
      LOCKED: begin
        if (sync) begin
          phase_d  = 3'd0;
          sync_err = (phase_q != 3'd7);
        end else begin
          phase_d  = phase_q + 3'd1;
          sync_err = (phase_q == 3'd7);
        end
      end
      default: begin
        lock_d  = UNLOCKED;
        phase_d = 3'd7;
      end
    endcase
  end

  // A new error event in the same clock as clear_err takes precedence over the clear.
  always_comb begin
    contention_d     = multi_en;
    keeper_d         = any_en ? win_data : keeper_q;
    err_sync_d       = err_sync_q;
    err_contention_d = err_contention_q;
    conflict_mask_d  = conflict_mask_q;
    conflict_count_d = conflict_count_q;
    if (clear_err) begin
      err_sync_d       = 1'b0;
      err_contention_d = 1'b0;
      conflict_mask_d  = '0;
      conflict_count_d = 8'd0;
    end
    if (sync_err) begin
      err_sync_d = 1'b1;
    end
    if (multi_en) begin
      err_contention_d = 1'b1;
      conflict_mask_d  = dev_data_en;
      if (clear_err) begin
        conflict_count_d = 8'd1;
      end else if (conflict_count_q != 8'hFF) begin
        conflict_count_d = conflict_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q           <= UNLOCKED;
      phase_q          <= 3'd7;
      contention_q     <= 1'b0;
      err_contention_q <= 1'b0;
      err_sync_q       <= 1'b0;
      conflict_mask_q  <= '0;
      conflict_count_q <= 8'd0;
      keeper_q         <= '0;
    end else begin
      lock_q           <= lock_d;
      phase_q          <= phase_d;
      contention_q     <= contention_d;
      err_contention_q <= err_contention_d;
      err_sync_q       <= err_sync_d;
      conflict_mask_q  <= conflict_mask_d;
      conflict_count_q <= conflict_count_d;
      keeper_q         <= keeper_d;
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: a KEEP=0 and a KEEP=1 instance share stimulus,
// driven from a vector table through an expectation queue, plus a long contention sequence.
`timescale 1ns/1ps
module tb_bus_fabric;

  logic        clock = 1'b0;
  logic        reset;
  logic        sync;
  logic [15:0] dev_data_o;
  logic [3:0]  dev_data_en;
  logic        clear_err;

  logic [3:0]  data0, data1;
  logic [2:0]  phase0, phase1;
  logic        pv0, pv1, cont0, cont1, errc0, errc1, errs0, errs1;
  logic [3:0]  mask0, mask1;
  logic [7:0]  cnt0, cnt1;

  typedef struct {
    logic        rst;
    logic        sync;
    logic [3:0]  en;
    logic [15:0] dv;
    logic        clr;
    logic [3:0]  data;
    logic [3:0]  datak;
    logic [2:0]  phase;
    logic        pv;
    logic        cont;
    logic        errc;
    logic        errs;
    logic [3:0]  mask;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   passCount  = 0;
  int   checkCount = 0;

  always #5 clock = ~clock;

  bus_fabric #(.NUM_DEV(4), .DATA_W(4), .KEEP(0)) u_dut0 (
    .clock(clock), .reset(reset), .sync(sync), .dev_data_o(dev_data_o),
    .dev_data_en(dev_data_en), .clear_err(clear_err), .data(data0), .phase(phase0),
    .phase_valid(pv0), .contention(cont0), .err_contention(errc0), .err_sync(errs0),
    .conflict_mask(mask0), .conflict_count(cnt0)
  );

  bus_fabric #(.NUM_DEV(4), .DATA_W(4), .KEEP(1)) u_dut1 (
    .clock(clock), .reset(reset), .sync(sync), .dev_data_o(dev_data_o),
    .dev_data_en(dev_data_en), .clear_err(clear_err), .data(data1), .phase(phase1),
    .phase_valid(pv1), .contention(cont1), .err_contention(errc1), .err_sync(errs1),
    .conflict_mask(mask1), .conflict_count(cnt1)
  );

  task automatic checkField(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic addRow(input logic rst, input logic sy, input logic [3:0] en, input logic [15:0] dv,
                        input logic clr, input logic [3:0] d, input logic [3:0] dk, input logic [2:0] ph,
                        input logic pv, input logic ct, input logic ec, input logic es,
                        input logic [3:0] mk, input logic [7:0] cn);
    vec_t v;
    v.rst = rst; v.sync = sy; v.en = en; v.dv = dv; v.clr = clr;
    v.data = d; v.datak = dk; v.phase = ph; v.pv = pv; v.cont = ct;
    v.errc = ec; v.errs = es; v.mask = mk; v.cnt = cn;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    reset       = v.rst;
    sync        = v.sync;
    dev_data_en = v.en;
    dev_data_o  = v.dv;
    clear_err   = v.clr;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      checkField($sformatf("row%0d scoreboard_empty", idx), 16'd1, 16'd0);
      return;
    end
    e = exp_q.pop_front();
    checkField($sformatf("row%0d data_k0", idx), 16'(data0), 16'(e.data));
    checkField($sformatf("row%0d data_k1", idx), 16'(data1), 16'(e.datak));
    checkField($sformatf("row%0d phase", idx), 16'(phase0), 16'(e.phase));
    checkField($sformatf("row%0d phase_k1", idx), 16'(phase1), 16'(e.phase));
    checkField($sformatf("row%0d phase_valid", idx), 16'(pv0), 16'(e.pv));
    checkField($sformatf("row%0d phase_valid_k1", idx), 16'(pv1), 16'(e.pv));
    checkField($sformatf("row%0d contention", idx), 16'(cont0), 16'(e.cont));
    checkField($sformatf("row%0d contention_k1", idx), 16'(cont1), 16'(e.cont));
    checkField($sformatf("row%0d err_contention", idx), 16'(errc0), 16'(e.errc));
    checkField($sformatf("row%0d err_contention_k1", idx), 16'(errc1), 16'(e.errc));
    checkField($sformatf("row%0d err_sync", idx), 16'(errs0), 16'(e.errs));
    checkField($sformatf("row%0d err_sync_k1", idx), 16'(errs1), 16'(e.errs));
    checkField($sformatf("row%0d conflict_mask", idx), 16'(mask0), 16'(e.mask));
    checkField($sformatf("row%0d conflict_mask_k1", idx), 16'(mask1), 16'(e.mask));
    checkField($sformatf("row%0d conflict_count", idx), 16'(cnt0), 16'(e.cnt));
    checkField($sformatf("row%0d conflict_count_k1", idx), 16'(cnt1), 16'(e.cnt));
  endtask

  initial begin
    logic [7:0] expCnt;
    reset = 1'b1; sync = 1'b0; dev_data_en = 4'h0; dev_data_o = 16'h0; clear_err = 1'b0;
    @(posedge clock); @(posedge clock); #1;

    // Reset state, then the first sync locks the tracker and phases run 0..7 twice.
    addRow(1,0,4'h0,16'hCA53,0, 4'h0,4'h0,3'd7,0,0,0,0,4'h0,8'd0);
    addRow(0,0,4'h0,16'hCA53,0, 4'h0,4'h0,3'd7,0,0,0,0,4'h0,8'd0);
    addRow(0,1,4'h0,16'hCA53,0, 4'h0,4'h0,3'd7,0,0,0,0,4'h0,8'd0);
    for (int i = 0; i < 16; i++)
      addRow(0,(i % 8 == 7),4'h0,16'hCA53,0, 4'h0,4'h0,3'(i % 8),1,0,0,0,4'h0,8'd0);
    // Agents 1 and 2 collide; agent 1 wins, the next clock shows the contention record.
    addRow(0,0,4'b0110,16'hCA53,0, 4'h5,4'h5,3'd0,1,0,0,0,4'h0,8'd0);
    addRow(0,0,4'h0,16'hCA53,0, 4'h0,4'h5,3'd1,1,1,1,0,4'b0110,8'd1);
    // Agent 3 drives 0xC once; the keeper instance holds it afterwards.
    addRow(0,0,4'b1000,16'hCA53,0, 4'hC,4'hC,3'd2,1,0,1,0,4'b0110,8'd1);
    // Early sync at phase 3 forces phase 7 immediately.
    addRow(0,1,4'h0,16'hCA53,0, 4'h0,4'hC,3'd7,1,0,1,0,4'b0110,8'd1);
    for (int i = 0; i < 8; i++)
      addRow(0,0,4'h0,16'hCA53,0, 4'h0,4'hC,3'(i),1,0,1,1,4'b0110,8'd1);
    // Missing sync kept err_sync set; clear it, then clear together with a new early sync.
    addRow(0,0,4'h0,16'hCA53,1, 4'h0,4'hC,3'd0,1,0,1,1,4'b0110,8'd1);
    addRow(0,1,4'h0,16'hCA53,1, 4'h0,4'hC,3'd7,1,0,0,0,4'h0,8'd0);
    addRow(0,0,4'b0001,16'hCA53,0, 4'h3,4'h3,3'd0,1,0,0,1,4'h0,8'd0);
    addRow(0,0,4'h0,16'hCA53,0, 4'h0,4'h3,3'd1,1,0,0,1,4'h0,8'd0);
    addRow(0,0,4'b1100,16'hCA53,0, 4'hA,4'hA,3'd2,1,0,0,1,4'h0,8'd0);
    addRow(0,0,4'h0,16'hCA53,0, 4'h0,4'hA,3'd3,1,1,1,1,4'b1100,8'd1);
    // Reset at phase 4 drops lock and clears everything; relock needs a fresh sync.
    addRow(1,0,4'h0,16'hCA53,0, 4'h0,4'hA,3'd4,1,0,1,1,4'b1100,8'd1);
    addRow(0,0,4'h0,16'hCA53,0, 4'h0,4'h0,3'd7,0,0,0,0,4'h0,8'd0);
    addRow(0,0,4'h0,16'hCA53,0, 4'h0,4'h0,3'd7,0,0,0,0,4'h0,8'd0);
    addRow(0,1,4'h0,16'hCA53,0, 4'h0,4'h0,3'd7,0,0,0,0,4'h0,8'd0);
    for (int i = 0; i < 8; i++)
      addRow(0,0,4'h0,16'hCA53,0, 4'h0,4'h0,3'(i),1,0,0,0,4'h0,8'd0);
    addRow(0,0,4'h0,16'hCA53,0, 4'h0,4'h0,3'd0,1,0,0,1,4'h0,8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i);
      @(posedge clock); #1;
    end

    // Long contention: the count saturates at 255, then clear_err with contention still present.
    reset = 1'b0; sync = 1'b0; clear_err = 1'b1; dev_data_en = 4'h0;
    @(posedge clock); #1;
    clear_err = 1'b0; dev_data_en = 4'b0011;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clock); #2;
      expCnt = (n > 255) ? 8'd255 : 8'(n);
      if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300) begin
        checkField($sformatf("sat n%0d conflict_count", n), 16'(cnt0), 16'(expCnt));
        checkField($sformatf("sat n%0d conflict_count_k1", n), 16'(cnt1), 16'(expCnt));
        checkField($sformatf("sat n%0d contention", n), 16'(cont0), 16'd1);
        checkField($sformatf("sat n%0d err_contention", n), 16'(errc0), 16'd1);
      end
    end
    clear_err = 1'b1;
    @(posedge clock); #2;
    checkField("clr_with_event conflict_count", 16'(cnt0), 16'd1);
    checkField("clr_with_event err_contention", 16'(errc0), 16'd1);
    checkField("clr_with_event contention", 16'(cont0), 16'd1);
    checkField("clr_with_event conflict_mask", 16'(mask0), 16'h3);
    dev_data_en = 4'h0;
    @(posedge clock); #2;
    checkField("clr_only conflict_count", 16'(cnt0), 16'd0);
    checkField("clr_only err_contention", 16'(errc0), 16'd0);
    checkField("clr_only contention", 16'(cont0), 16'd0);
    checkField("clr_only conflict_mask", 16'(mask0), 16'h0);
    clear_err = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
